music_sequencer: RTL and testbench
==================================

// Module: music_sequencer
// PURPOSE
//  Parametrised playlist/record sequencer driving the tone generator with a phase-increment word.
//  Plays NUM_SONGS note ROMs in sequential, random (no immediate repeat) or chosen order.
//  Records keyboard notes into an internal buffer, replays that buffer, and passes live keys through.
//  Sits between the song ROMs / keyboard decoder and the audio tone generator.
// PARAMETERS
//  NUM_SONGS    4        number of song ROMs (2..8)
//  ADDR_W       11       ROM address width
//  NOTE_W       16       note frequency width, in Hz
//  LEN_W        10       song length field width
//  SONG_LENS    {10'd260,10'd260,10'd220,10'd270}  packed lengths; song i occupies [i*LEN_W +: LEN_W]
//  REC_DEPTH    512      record buffer entries (power of 2)
//  REPLAY_TICKS 4        ticks each recorded note is held during replay
// PORTS
//  clk        in   1          system clock
//  reset      in   1          synchronous, active-high reset
//  tick       in   1          note-rate enable, 1-cycle pulse (48 Hz)
//  pause      in   1          1 = mute and freeze all counters
//  mode       in   3          0 SEQ, 1 RAND, 2 CHOICE, 3 RECORD, 4 REPLAY, 5 LIVE, 6/7 idle
//  choice     in   3          song index used in CHOICE mode
//  rom_song   out  3          selected ROM (mux select)
//  rom_addr   out  ADDR_W     ROM read address; ROM data returns 1 cycle later
//  rom_data   in   NOTE_W     note from the selected ROM
//  key_valid  in   1          1-cycle strobe: key_note is new
//  key_note   in   NOTE_W     keyboard note frequency
//  phase_inc  out  16         tone word = note*65536/48000
//  song_idx   out  3          song currently playing
//  rec_count  out  log2(REC_DEPTH)+1  notes recorded
//  rec_full   out  1          rec_count == REC_DEPTH
// BEHAVIOUR
//  Reset: phase_inc=0, rom_addr=0, rom_song=0, song_idx=0, rec_count=0, rec_full=0, replay ptr/hold=0,
//   LFSR=16'hACE1 (x^16+x^14+x^13+x^11+1, steps every clk). Reset mid-song aborts it immediately.
//  Conversion: phase_inc = (note<<16)/48000, with a >=33-bit intermediate; saturates to 16'hFFFF if >0xFFFF.
//  ROM playback (modes 0-2), on each tick with pause=0:
//   - if rom_addr >= len(song_idx): rom_addr<=0 and select the next song:
//     SEQ = (song_idx+1) mod NUM_SONGS; RAND = lfsr mod NUM_SONGS, +1 mod NUM_SONGS if equal to song_idx;
//     CHOICE = choice (clamped to NUM_SONGS-1).
//   - else rom_addr<=rom_addr+1.
//   - phase_inc is registered from rom_data 2 clk after the tick.
//   - In CHOICE mode, a change of choice restarts at rom_addr 0 on the next tick.
//  Mode change (mode differs from the previous cycle's registered value): rom_addr<=0 and replay ptr<=0 that cycle.
//   Entry song: SEQ keeps song_idx; RAND draws from the LFSR; CHOICE takes choice.
//  RECORD (3): phase_inc = converted key_note while key held (updated on key_valid).
//   - Entering RECORD clears rec_count.
//   - key_valid && !rec_full -> buf[rec_count]<=key_note, rec_count++.
//   - key_valid when full is dropped; rec_full stays 1.
//  REPLAY (4): if rec_count==0, phase_inc=0.
//   - Otherwise output buf[ptr]; on each tick hold++; at REPLAY_TICKS-1 hold<=0 and ptr++.
//   - ptr wraps to 0 after rec_count-1.
//  LIVE (5): phase_inc = converted key_note, updated 1 clk after key_valid.
//  Modes 6/7: phase_inc=0; all state held.
//  pause=1 (any mode): phase_inc=0 next clk.
//   - rom_addr, song, ptr, hold and rec_count are frozen; ticks and key_valid are ignored.
//   - Releasing pause resumes from the frozen position.
//  Simultaneous: reset > pause > mode change > tick/key_valid.
// TESTING
//  T1 SEQ, lens 3/3/3/3, ROM0=440: first note phase_inc=600; after 4 ticks song_idx 0->1; after 16 ticks wraps to 0.
//  T2 RAND, 200 song ends -> song_idx never repeats consecutively; every index 0..3 appears.
//  T3 RECORD: 513 key_valid with REC_DEPTH=512 -> rec_count=512, rec_full=1, 513th note dropped.
//  T4 REPLAY with 3 notes {262,294,330}: each held 4 ticks, phase_inc 357,401,450, then wraps to 262.
//  T5 pause at rom_addr=100 for 50 ticks -> phase_inc=0, rom_addr=100; on release resumes at 101.
//  T6 reset asserted mid-REPLAY and mid-song; key_note=60000 in LIVE -> all outputs at reset values; phase_inc=16'hFFFF.

Source files
------------

// File: rtl/music_sequencer.sv
// Playlist/record sequencer: plays song ROMs in sequential, random or chosen order, records and
// replays keyboard notes, passes live keys through, and drives the tone generator's phase word.
module music_sequencer #(
   parameter int unsigned                 NUM_SONGS    = 4,
   parameter int unsigned                 ADDR_W       = 11,
   parameter int unsigned                 NOTE_W       = 16,
   parameter int unsigned                 LEN_W        = 10,
   parameter logic [NUM_SONGS*LEN_W-1:0]  SONG_LENS    = {10'd260, 10'd260, 10'd220, 10'd270},
   parameter int unsigned                 REC_DEPTH    = 512,
   parameter int unsigned                 REPLAY_TICKS = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         tick,
   input  logic                         pause,
   input  logic [2:0]                   mode,
   input  logic [2:0]                   choice,
   output logic [2:0]                   rom_song,
   output logic [ADDR_W-1:0]            rom_addr,
   input  logic [NOTE_W-1:0]            rom_data,
   input  logic                         key_valid,
   input  logic [NOTE_W-1:0]            key_note,
   output logic [15:0]                  phase_inc,
   output logic [2:0]                   song_idx,
   output logic [$clog2(REC_DEPTH):0]   rec_count,
   output logic                         rec_full
);

   typedef enum logic [2:0] {
      M_SEQ    = 3'd0,
      M_RAND   = 3'd1,
      M_CHOICE = 3'd2,
      M_RECORD = 3'd3,
      M_REPLAY = 3'd4,
      M_LIVE   = 3'd5,
      M_IDLE6  = 3'd6,
      M_IDLE7  = 3'd7
   } mode_e;

   localparam int unsigned        REC_W    = $clog2(REC_DEPTH);
   localparam int unsigned        HOLD_W   = (REPLAY_TICKS > 1) ? $clog2(REPLAY_TICKS) : 1;
   localparam logic [NOTE_W+16:0] TONE_DIV = (NOTE_W+17)'(48000);
   localparam logic [NOTE_W+16:0] TONE_MAX = (NOTE_W+17)'(16'hFFFF);

   mode_e               mode_in, mode_q, mode_d;
   logic [2:0]          song_q, song_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [15:0]         lfsr_q, lfsr_d;
   logic [15:0]         phase_q, phase_d;
   logic [REC_W:0]      rec_count_q, rec_count_d;
   logic [REC_W-1:0]    ptr_q, ptr_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [1:0]          tk_q, tk_d;
   logic                rec_we;
   logic                rec_full_w;
   logic [2:0]          choice_cl;
   logic [LEN_W-1:0]    cur_len;
   logic [NOTE_W-1:0]   rec_buf_q [REC_DEPTH];

   // note * 65536 / 48000 with a wide intermediate, saturating at 16 bits
   function automatic logic [15:0] to_phase(input logic [NOTE_W-1:0] note);
      logic [NOTE_W+16:0] scaled;
      scaled = {1'b0, note, 16'h0000} / TONE_DIV;
      return (scaled > TONE_MAX) ? 16'hFFFF : scaled[15:0];
   endfunction

   function automatic logic [2:0] rand_pick(input logic [15:0] lfsr, input logic [2:0] cur);
      logic [2:0] r;
      r = 3'(lfsr % 16'(NUM_SONGS));
      if (r == cur) r = (32'(r) == NUM_SONGS - 1) ? 3'd0 : r + 3'd1;
      return r;
   endfunction

   assign mode_in    = mode_e'(mode);
   assign choice_cl  = (32'(choice) >= NUM_SONGS) ? 3'(NUM_SONGS - 1) : choice;
   assign cur_len    = SONG_LENS[song_q*LEN_W +: LEN_W];
   assign rec_full_w = (32'(rec_count_q) == REC_DEPTH);

   always_comb begin
      mode_d      = mode_in;
      song_d      = song_q;
      rom_addr_d  = rom_addr_q;
      lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      phase_d     = phase_q;
      rec_count_d = rec_count_q;
      ptr_d       = ptr_q;
      hold_d      = hold_q;
      tk_d        = {tk_q[0], 1'b0};
      rec_we      = 1'b0;

      if (pause) begin
         // mode is frozen too, so a change made while paused is acted on at release
         mode_d  = mode_q;
         phase_d = '0;
         tk_d    = '0;
      end else if (mode_in != mode_q) begin
         rom_addr_d = '0;
         ptr_d      = '0;
         hold_d     = '0;
         phase_d    = '0;
         tk_d       = '0;
         case (mode_in)
            M_RAND:   song_d      = rand_pick(lfsr_q, song_q);
            M_CHOICE: song_d      = choice_cl;
            M_RECORD: rec_count_d = '0;
            default: ;
         endcase
      end else begin
         case (mode_q)
            M_SEQ, M_RAND, M_CHOICE: begin
               if (tick) begin
                  tk_d[0] = 1'b1;
                  if (mode_q == M_CHOICE && choice_cl != song_q) begin
                     rom_addr_d = '0;
                     song_d     = choice_cl;
                  end else if (32'(rom_addr_q) >= 32'(cur_len)) begin
                     rom_addr_d = '0;
                     case (mode_q)
                        M_SEQ:   song_d = (32'(song_q) == NUM_SONGS - 1) ? 3'd0 : song_q + 3'd1;
                        M_RAND:  song_d = rand_pick(lfsr_q, song_q);
                        default: song_d = choice_cl;
                     endcase
                  end else begin
                     rom_addr_d = rom_addr_q + ADDR_W'(1);
                  end
               end
               // ROM data for the address set by a tick is ready two clocks later
               if (tk_q[1]) phase_d = to_phase(rom_data);
            end
            M_RECORD: begin
               if (key_valid) begin
                  phase_d = to_phase(key_note);
                  if (!rec_full_w) begin
                     rec_we      = 1'b1;
                     rec_count_d = rec_count_q + (REC_W+1)'(1);
                  end
               end
            end
            M_REPLAY: begin
               if (rec_count_q == '0) begin
                  phase_d = '0;
               end else begin
                  if (tick) begin
                     if (hold_q == HOLD_W'(REPLAY_TICKS - 1)) begin
                        hold_d = '0;
                        ptr_d  = (32'(ptr_q) + 32'd1 >= 32'(rec_count_q)) ? '0 : ptr_q + REC_W'(1);
                     end else begin
                        hold_d = hold_q + HOLD_W'(1);
                     end
                  end
                  phase_d = to_phase(rec_buf_q[ptr_d]);
               end
            end
            M_LIVE: begin
               if (key_valid) phase_d = to_phase(key_note);
            end
            default: phase_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q      <= M_SEQ;
         song_q      <= '0;
         rom_addr_q  <= '0;
         lfsr_q      <= 16'hACE1;
         phase_q     <= '0;
         rec_count_q <= '0;
         ptr_q       <= '0;
         hold_q      <= '0;
         tk_q        <= '0;
      end else begin
         mode_q      <= mode_d;
         song_q      <= song_d;
         rom_addr_q  <= rom_addr_d;
         lfsr_q      <= lfsr_d;
         phase_q     <= phase_d;
         rec_count_q <= rec_count_d;
         ptr_q       <= ptr_d;
         hold_q      <= hold_d;
         tk_q        <= tk_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rec_we) rec_buf_q[rec_count_q[REC_W-1:0]] <= key_note;
   end

   assign rom_song  = song_q;
   assign song_idx  = song_q;
   assign rom_addr  = rom_addr_q;
   assign phase_inc = phase_q;
   assign rec_count = rec_count_q;
   assign rec_full  = rec_full_w;

endmodule

// File: tb/tb_music_sequencer.sv
// Self-checking bench for music_sequencer: randomized playback, record, replay, live and pause
// scenarios compared against a behavioural model of the playlist rules.
`timescale 1ns/1ps
module tb_music_sequencer;

   localparam int unsigned NS    = 4;
   localparam int unsigned DEPTH = 512;

   logic        clk = 1'b0;
   logic        reset, tick, pause, key_valid;
   logic [2:0]  mode, choice, rom_song, song_idx;
   logic [10:0] rom_addr;
   logic [15:0] rom_data, key_note, phase_inc;
   logic [9:0]  rec_count;
   logic        rec_full;

   int unsigned vectors = 0, miscompares = 0;
   int unsigned m_song, m_addr;
   logic [15:0] m_lfsr;
   int unsigned rec_notes[$];

   always #5 clk = ~clk;

   music_sequencer #(
      .NUM_SONGS(4), .ADDR_W(11), .NOTE_W(16), .LEN_W(10),
      .SONG_LENS({10'd120, 10'd3, 10'd3, 10'd3}),
      .REC_DEPTH(512), .REPLAY_TICKS(4)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick), .pause(pause), .mode(mode), .choice(choice),
      .rom_song(rom_song), .rom_addr(rom_addr), .rom_data(rom_data),
      .key_valid(key_valid), .key_note(key_note), .phase_inc(phase_inc),
      .song_idx(song_idx), .rec_count(rec_count), .rec_full(rec_full)
   );

   function automatic logic [15:0] rom_fn(input logic [2:0] s, input logic [10:0] a);
      if (s == 3'd0) return 16'd440;
      return 16'(100 + 150 * int'(s) + 3 * int'(a));
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_song, rom_addr);

   always @(posedge clk) begin
      if (reset) m_lfsr <= 16'hACE1;
      else m_lfsr <= (m_lfsr >> 1) |
                     16'((((m_lfsr >> 0) ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 16'd1) << 15);
   end

   function automatic int unsigned len_of(input int unsigned s);
      case (s)
         3:       return 120;
         default: return 3;
      endcase
   endfunction

   function automatic logic [15:0] conv(input int unsigned note);
      longint unsigned v;
      v = (longint'(note) * 65536) / 48000;
      return (v > 65535) ? 16'hFFFF : 16'(v);
   endfunction

   function automatic int unsigned clampc(input logic [2:0] c);
      return (int'(c) >= NS) ? NS - 1 : int'(c);
   endfunction

   function automatic int unsigned rnd(input int unsigned cur);
      int unsigned r;
      r = int'(m_lfsr) % NS;
      if (r == cur) r = (r + 1) % NS;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic rom_model_tick(input int unsigned md);
      if (md == 2 && clampc(choice) != m_song) begin
         m_addr = 0;
         m_song = clampc(choice);
      end else if (m_addr >= len_of(m_song)) begin
         m_addr = 0;
         case (md)
            0:       m_song = (m_song + 1) % NS;
            1:       m_song = rnd(m_song);
            default: m_song = clampc(choice);
         endcase
      end else begin
         m_addr++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick = 0; pause = 0; mode = 0; choice = 0; key_valid = 0; key_note = 0;
      repeat (3) step();
      vectors++;
      if (phase_inc !== 16'd0 || rom_addr !== 11'd0 || rom_song !== 3'd0 || song_idx !== 3'd0 ||
          rec_count !== 10'd0 || rec_full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: phase=%0d addr=%0d song=%0d idx=%0d cnt=%0d full=%0d, all required 0",
                  phase_inc, rom_addr, rom_song, song_idx, rec_count, rec_full);
      end
      reset = 1'b0;
      m_song = 0; m_addr = 0;
      step();
   endtask

   task automatic test_seq();
      mode = 3'd0;
      for (int i = 0; i < 40; i++) begin
         rom_model_tick(0);
         do_tick();
         vectors++;
         if (rom_addr !== 11'(m_addr) || song_idx !== 3'(m_song) || rom_song !== 3'(m_song)) begin
            miscompares++;
            $display("FAIL seq_pos: addr=%0d song=%0d rom_song=%0d, required addr=%0d song=%0d",
                     rom_addr, song_idx, rom_song, m_addr, m_song);
         end
         step(); step();
         vectors++;
         if (phase_inc !== conv(rom_fn(3'(m_song), 11'(m_addr)))) begin
            miscompares++;
            $display("FAIL seq_phase: got %0d required %0d", phase_inc, conv(rom_fn(3'(m_song), 11'(m_addr))));
         end
         if (i == 0) begin
            vectors++;
            if (phase_inc !== 16'd600) begin
               miscompares++;
               $display("FAIL seq_first_note: got %0d required 600", phase_inc);
            end
         end
      end
   endtask

   task automatic test_rand();
      int unsigned ends = 0, nt = 0;
      logic [2:0]  prev;
      bit          seen [4];
      mode = 3'd1;
      m_addr = 0;
      m_song = rnd(m_song);
      step();
      vectors++;
      if (song_idx !== 3'(m_song) || rom_addr !== 11'd0) begin
         miscompares++;
         $display("FAIL rand_entry: song=%0d addr=%0d required song=%0d addr=0", song_idx, rom_addr, m_song);
      end
      prev = song_idx;
      while (ends < 200 && nt < 20000) begin
         rom_model_tick(1);
         do_tick();
         nt++;
         vectors++;
         if (rom_addr !== 11'(m_addr) || song_idx !== 3'(m_song)) begin
            miscompares++;
            $display("FAIL rand_pos: addr=%0d song=%0d required addr=%0d song=%0d", rom_addr, song_idx, m_addr, m_song);
         end
         if (m_addr == 0) begin
            ends++;
            vectors++;
            if (song_idx === prev) begin
               miscompares++;
               $display("FAIL rand_repeat: song %0d repeated, required a different song", song_idx);
            end
            seen[song_idx[1:0]] = 1'b1;
            prev = song_idx;
         end
         step();
      end
      vectors++;
      if (ends != 200) begin
         miscompares++;
         $display("FAIL rand_ends: got %0d song ends required 200 within budget", ends);
      end
      vectors++;
      if (!(seen[0] && seen[1] && seen[2] && seen[3])) begin
         miscompares++;
         $display("FAIL rand_cover: seen=%0d%0d%0d%0d required 1111", seen[3], seen[2], seen[1], seen[0]);
      end
   endtask

   task automatic test_choice();
      choice = 3'($urandom_range(0, 7));
      mode = 3'd2;
      m_addr = 0;
      m_song = clampc(choice);
      step();
      vectors++;
      if (song_idx !== 3'(m_song) || rom_addr !== 11'd0) begin
         miscompares++;
         $display("FAIL choice_entry: song=%0d addr=%0d required song=%0d addr=0", song_idx, rom_addr, m_song);
      end
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) choice = 3'($urandom_range(0, 7));
         rom_model_tick(2);
         do_tick();
         vectors++;
         if (rom_addr !== 11'(m_addr) || song_idx !== 3'(m_song)) begin
            miscompares++;
            $display("FAIL choice_pos: addr=%0d song=%0d required addr=%0d song=%0d", rom_addr, song_idx, m_addr, m_song);
         end
         step(); step();
         vectors++;
         if (phase_inc !== conv(rom_fn(3'(m_song), 11'(m_addr)))) begin
            miscompares++;
            $display("FAIL choice_phase: got %0d required %0d", phase_inc, conv(rom_fn(3'(m_song), 11'(m_addr))));
         end
      end
   endtask

   task automatic test_pause();
      int unsigned guard = 0;
      choice = 3'd3;
      while (!(m_song == 3 && m_addr == 100) && guard < 400) begin
         rom_model_tick(2);
         do_tick();
         step();
         guard++;
      end
      step(); step();
      vectors++;
      if (rom_addr !== 11'd100 || phase_inc !== conv(rom_fn(3'd3, 11'd100))) begin
         miscompares++;
         $display("FAIL pause_setup: addr=%0d phase=%0d required addr=100 phase=%0d",
                  rom_addr, phase_inc, conv(rom_fn(3'd3, 11'd100)));
      end
      pause = 1'b1;
      step();
      vectors++;
      if (phase_inc !== 16'd0) begin
         miscompares++;
         $display("FAIL pause_mute: got %0d required 0", phase_inc);
      end
      for (int i = 0; i < 50; i++) begin
         key_valid = 1'($urandom_range(0, 1));
         do_tick();
         key_valid = 1'b0;
      end
      vectors++;
      if (rom_addr !== 11'd100 || song_idx !== 3'd3 || phase_inc !== 16'd0) begin
         miscompares++;
         $display("FAIL pause_frozen: addr=%0d song=%0d phase=%0d required 100/3/0", rom_addr, song_idx, phase_inc);
      end
      pause = 1'b0;
      step();
      rom_model_tick(2);
      do_tick();
      vectors++;
      if (rom_addr !== 11'd101) begin
         miscompares++;
         $display("FAIL pause_resume: addr=%0d required 101", rom_addr);
      end
      step(); step();
      vectors++;
      if (phase_inc !== conv(rom_fn(3'd3, 11'd101))) begin
         miscompares++;
         $display("FAIL pause_resume_phase: got %0d required %0d", phase_inc, conv(rom_fn(3'd3, 11'd101)));
      end
   endtask

   task automatic test_record();
      int unsigned note, expc;
      mode = 3'd3;
      step();
      vectors++;
      if (rec_count !== 10'd0 || rec_full !== 1'b0) begin
         miscompares++;
         $display("FAIL rec_entry: cnt=%0d full=%0d required 0/0", rec_count, rec_full);
      end
      rec_notes.delete();
      for (int n = 0; n < 513; n++) begin
         if (n == 300) begin
            pause = 1'b1;
            key_note = 16'd1234; key_valid = 1'b1;
            step(); step();
            key_valid = 1'b0;
            vectors++;
            if (rec_count !== 10'd300 || phase_inc !== 16'd0) begin
               miscompares++;
               $display("FAIL rec_pause: cnt=%0d phase=%0d required 300/0", rec_count, phase_inc);
            end
            pause = 1'b0;
            step();
         end
         note = $urandom_range(100, 4000);
         key_note = 16'(note);
         key_valid = 1'b1;
         step();
         key_valid = 1'b0;
         if (n < DEPTH) rec_notes.push_back(note);
         expc = (n + 1 < DEPTH) ? n + 1 : DEPTH;
         vectors++;
         if (rec_count !== 10'(expc) || rec_full !== (expc == DEPTH) || phase_inc !== conv(note)) begin
            miscompares++;
            $display("FAIL rec_note%0d: cnt=%0d full=%0d phase=%0d required %0d/%0d/%0d",
                     n, rec_count, rec_full, phase_inc, expc, (expc == DEPTH), conv(note));
         end
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   task automatic test_replay_full();
      int unsigned p = 0, h = 0;
      mode = 3'd4;
      step(); step();
      vectors++;
      if (phase_inc !== conv(rec_notes[0])) begin
         miscompares++;
         $display("FAIL replay_first: got %0d required %0d", phase_inc, conv(rec_notes[0]));
      end
      for (int i = 0; i < 80; i++) begin
         if (h == 3) begin h = 0; p = (p + 1) % rec_notes.size(); end
         else h++;
         do_tick();
         vectors++;
         if (phase_inc !== conv(rec_notes[p])) begin
            miscompares++;
            $display("FAIL replay_full: tick %0d got %0d required %0d", i, phase_inc, conv(rec_notes[p]));
         end
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   task automatic test_replay3();
      int unsigned notes [3] = '{262, 294, 330};
      logic [15:0] expw [3]  = '{16'd357, 16'd401, 16'd450};
      int unsigned p = 0, h = 0;
      mode = 3'd7; step();
      mode = 3'd3; step();
      for (int i = 0; i < 3; i++) begin
         key_note = 16'(notes[i]); key_valid = 1'b1; step(); key_valid = 1'b0; step();
      end
      vectors++;
      if (rec_count !== 10'd3 || rec_full !== 1'b0) begin
         miscompares++;
         $display("FAIL replay3_count: cnt=%0d full=%0d required 3/0", rec_count, rec_full);
      end
      mode = 3'd4;
      step(); step();
      vectors++;
      if (phase_inc !== expw[0]) begin
         miscompares++;
         $display("FAIL replay3_first: got %0d required %0d", phase_inc, expw[0]);
      end
      for (int i = 0; i < 28; i++) begin
         if (h == 3) begin h = 0; p = (p + 1) % 3; end
         else h++;
         do_tick();
         step();
         vectors++;
         if (phase_inc !== expw[p]) begin
            miscompares++;
            $display("FAIL replay3_tick%0d: got %0d required %0d", i, phase_inc, expw[p]);
         end
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      step();
      vectors++;
      if (phase_inc !== 16'd0 || rom_addr !== 11'd0 || song_idx !== 3'd0 || rec_count !== 10'd0 || rec_full !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_replay: phase=%0d addr=%0d song=%0d cnt=%0d full=%0d required all 0",
                  phase_inc, rom_addr, song_idx, rec_count, rec_full);
      end
      reset = 1'b0; mode = 3'd0;
      m_song = 0; m_addr = 0;
      step();
      for (int i = 0; i < 6; i++) begin
         rom_model_tick(0);
         do_tick();
         step();
      end
      vectors++;
      if (rom_addr !== 11'(m_addr) || song_idx !== 3'(m_song)) begin
         miscompares++;
         $display("FAIL reset_pre_song: addr=%0d song=%0d required %0d/%0d", rom_addr, song_idx, m_addr, m_song);
      end
      reset = 1'b1;
      step();
      vectors++;
      if (phase_inc !== 16'd0 || rom_addr !== 11'd0 || song_idx !== 3'd0 || rom_song !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_song: phase=%0d addr=%0d song=%0d rom_song=%0d required all 0",
                  phase_inc, rom_addr, song_idx, rom_song);
      end
      reset = 1'b0;
      m_song = 0; m_addr = 0;
      step();
   endtask

   task automatic test_live();
      int unsigned notes [6] = '{60000, 0, 440, 48000, 47999, 65535};
      int unsigned n;
      mode = 3'd5;
      step();
      for (int i = 0; i < 14; i++) begin
         n = (i < 6) ? notes[i] : $urandom_range(0, 65535);
         key_note = 16'(n); key_valid = 1'b1;
         step();
         key_valid = 1'b0;
         vectors++;
         if (phase_inc !== conv(n)) begin
            miscompares++;
            $display("FAIL live_note%0d: note=%0d got %0d required %0d", i, n, phase_inc, conv(n));
         end
         if (i == 0) begin
            vectors++;
            if (phase_inc !== 16'hFFFF) begin
               miscompares++;
               $display("FAIL live_saturate: got %0h required ffff", phase_inc);
            end
         end
         key_note = 16'($urandom_range(0, 65535));
         step();
         vectors++;
         if (phase_inc !== conv(n)) begin
            miscompares++;
            $display("FAIL live_hold%0d: got %0d required %0d", i, phase_inc, conv(n));
         end
      end
   endtask

   task automatic test_replay_empty();
      mode = 3'd3; step();
      mode = 3'd4; step(); step();
      for (int i = 0; i < 6; i++) begin
         do_tick();
         vectors++;
         if (phase_inc !== 16'd0 || rec_count !== 10'd0) begin
            miscompares++;
            $display("FAIL replay_empty: phase=%0d cnt=%0d required 0/0", phase_inc, rec_count);
         end
      end
   endtask

   task automatic test_idle();
      mode = 3'd6;
      step();
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin mode = 3'd7; step(); end
         key_note = 16'd1000; key_valid = 1'b1;
         do_tick();
         key_valid = 1'b0;
         vectors++;
         if (phase_inc !== 16'd0 || song_idx !== 3'(m_song) || rom_addr !== 11'd0 || rec_count !== 10'd0) begin
            miscompares++;
            $display("FAIL idle_hold: phase=%0d song=%0d addr=%0d cnt=%0d required 0/%0d/0/0",
                     phase_inc, song_idx, rom_addr, rec_count, m_song);
         end
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_seq();
      test_rand();
      test_choice();
      test_pause();
      test_record();
      test_replay_full();
      test_replay3();
      test_reset_mid();
      test_live();
      test_replay_empty();
      test_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
